// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer tone generator: default widths and FSM state codes.
package buzzer_pkg;

   localparam int BUZ_CNT_W = 24;
   localparam int BUZ_DUR_W = 24;
   localparam int BUZ_NUM_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONT = 2'd1;
   localparam logic [1:0] ST_ON   = 2'd2;
   localparam logic [1:0] ST_OFF  = 2'd3;

   function automatic logic is_tone_state(input logic [1:0] st);
      return (st == ST_CONT) || (st == ST_ON);
   endfunction

endpackage

// File: rtl/buzzer_tone_core.sv
// Square-wave core: half-period counter plus toggle register, divisor re-sampled at each toggle.
module buzzer_tone_core
   import buzzer_pkg::*;
#(
   parameter int CNT_W = BUZ_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clr,
   input  logic [CNT_W-1:0] div,
   output logic             tone
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_q;

   // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch, and every state update uses <= so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt   <= '0;
         div_q <= '0;
         tone  <= 1'b0;
      end else if (clr || !run) begin
         // Holding here keeps the divisor tracking the input until the tone starts.
         cnt   <= '0;
         div_q <= div;
         tone  <= 1'b0;
      end else if (cnt == div_q) begin
         cnt   <= '0;
         div_q <= div;
         tone  <= ~tone;
      end else begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Buzzer driver: continuous tone or burst of N beeps with programmable on/off lengths.
module buzzer_tone_gen
   import buzzer_pkg::*;
#(
   parameter int CNT_W = BUZ_CNT_W,
   parameter int DUR_W = BUZ_DUR_W,
   parameter int NUM_W = BUZ_NUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             en,
   input  logic             start,
   input  logic [CNT_W-1:0] tone_div,
   input  logic [NUM_W-1:0] beep_count,
   input  logic [DUR_W-1:0] on_len,
   input  logic [DUR_W-1:0] off_len,
   output logic             pwm_out,
   output logic             busy,
   output logic             done
);

   logic [1:0]       state;
   logic [1:0]       nxt;
   logic [DUR_W-1:0] dur_cnt;
   logic [DUR_W-1:0] on_len_q;
   logic [DUR_W-1:0] off_len_q;
   logic [CNT_W-1:0] tone_div_q;
   logic [NUM_W-1:0] beeps_left;
   logic [CNT_W-1:0] core_div;
   logic             core_run;
   logic             core_clr;

   // NOTE: nxt gets a default before the case so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (!mode && en)
               nxt = ST_CONT;
            else if (mode && start && (beep_count != '0))
               nxt = ST_ON;
         end
         ST_CONT: if (!en || mode) nxt = ST_IDLE;
         ST_ON: begin
            if (dur_cnt == on_len_q)
               nxt = (beeps_left == NUM_W'(1)) ? ST_IDLE : ST_OFF;
         end
         ST_OFF:  if (dur_cnt == off_len_q) nxt = ST_ON;
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         dur_cnt    <= '0;
         on_len_q   <= '0;
         off_len_q  <= '0;
         tone_div_q <= '0;
         beeps_left <= '0;
         done       <= 1'b0;
      end else begin
         state <= nxt;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               dur_cnt <= '0;
               if (mode && start) begin
                  if (beep_count != '0) begin
                     on_len_q   <= on_len;
                     off_len_q  <= off_len;
                     tone_div_q <= tone_div;
                     beeps_left <= beep_count;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_ON: begin
               if (dur_cnt == on_len_q) begin
                  dur_cnt <= '0;
                  if (beeps_left == NUM_W'(1))
                     done <= 1'b1;
                  else
                     beeps_left <= beeps_left - NUM_W'(1);
               end else begin
                  dur_cnt <= dur_cnt + DUR_W'(1);
               end
            end
            ST_OFF: begin
               if (dur_cnt == off_len_q)
                  dur_cnt <= '0;
               else
                  dur_cnt <= dur_cnt + DUR_W'(1);
            end
            default: dur_cnt <= '0;
         endcase
      end
   end

   // Bursts play on the latched divisor; continuous mode follows the live input.
   assign core_div = ((state == ST_ON) || (state == ST_OFF)) ? tone_div_q : tone_div;
   assign core_run = is_tone_state(state);
   assign core_clr = (nxt != state);
   assign busy     = (state == ST_ON) || (state == ST_OFF);

   buzzer_tone_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk  (clk),
      .rst  (rst),
      .run  (core_run),
      .clr  (core_clr),
      .div  (core_div),
      .tone (pwm_out)
   );

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench: directed scenarios then random traffic against a timestamp-based model.
module tb_buzzer_tone_gen;

   localparam int CNT_W = 24;
   localparam int DUR_W = 24;
   localparam int NUM_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             mode;
   logic             en;
   logic             start;
   logic [CNT_W-1:0] tone_div;
   logic [NUM_W-1:0] beep_count;
   logic [DUR_W-1:0] on_len;
   logic [DUR_W-1:0] off_len;
   logic             pwm_out;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   buzzer_tone_gen #(
      .CNT_W (CNT_W),
      .DUR_W (DUR_W),
      .NUM_W (NUM_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .en         (en),
      .start      (start),
      .tone_div   (tone_div),
      .beep_count (beep_count),
      .on_len     (on_len),
      .off_len    (off_len),
      .pwm_out    (pwm_out),
      .busy       (busy),
      .done       (done)
   );

   int    n_cmp = 0;
   int    n_bad = 0;
   longint cyc = 0;
   int    done_seen = 0;

   // Reference model: 0 idle, 1 continuous, 2 burst; timing from edge timestamps.
   int     m_kind = 0;
   bit     m_pwm  = 1'b0;
   bit     m_done = 1'b0;
   longint next_tog, t0, b_len;
   int     b_on, b_off, b_div;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit m, input bit e, input bit s,
                             input int td, input int bc, input int ol, input int fl);
      longint j;
      int     p;
      m_done = 1'b0;
      if (!r) begin
         m_kind = 0;
         m_pwm  = 1'b0;
      end else begin
         case (m_kind)
            0: begin
               if (!m && e) begin
                  m_kind   = 1;
                  m_pwm    = 1'b0;
                  next_tog = cyc + td + 1;
               end else if (m && s) begin
                  if (bc != 0) begin
                     m_kind = 2;
                     t0     = cyc;
                     b_on   = ol + 1;
                     b_off  = fl + 1;
                     b_div  = td + 1;
                     b_len  = longint'(bc) * b_on + longint'(bc - 1) * b_off;
                     m_pwm  = 1'b0;
                  end else begin
                     m_done = 1'b1;
                  end
               end
            end
            1: begin
               if (!e || m) begin
                  m_kind = 0;
                  m_pwm  = 1'b0;
               end else if (cyc == next_tog) begin
                  m_pwm    = ~m_pwm;
                  next_tog = cyc + td + 1;
               end
            end
            default: begin
               j = cyc - t0;
               if (j >= b_len) begin
                  m_kind = 0;
                  m_done = 1'b1;
                  m_pwm  = 1'b0;
               end else begin
                  p     = int'(j % (b_on + b_off));
                  m_pwm = (p < b_on) ? (((p / b_div) % 2) == 1) : 1'b0;
               end
            end
         endcase
      end
   endtask

   task automatic tick(input int n);
      bit r, m, e, s;
      int td, bc, ol, fl;
      repeat (n) begin
         r  = rst;
         m  = mode;
         e  = en;
         s  = start;
         td = int'(tone_div);
         bc = int'(beep_count);
         ol = int'(on_len);
         fl = int'(off_len);
         @(posedge clk);
         cyc++;
         model_edge(r, m, e, s, td, bc, ol, fl);
         #1;
         check("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
         check("busy", {31'd0, busy}, {31'd0, (m_kind == 2)});
         check("done", {31'd0, done}, {31'd0, m_done});
         if (done) done_seen++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      int waited;
      rst = 1'b0; mode = 1'b0; en = 1'b1; start = 1'b0;
      tone_div = 2; beep_count = 0; on_len = 0; off_len = 0;

      // Reset held with en high, then release into continuous mode
      tick(3);
      rst = 1'b1;
      tick(12);

      // Continuous: period 8, then divisor change, then disable
      tone_div = 3;
      tick(24);
      tone_div = 1;
      tick(12);
      en = 1'b0;
      tick(3);

      // Burst 3 x (10 on, 5 off) at clk/4
      mode = 1'b1; beep_count = 3; on_len = 9; off_len = 4; tone_div = 1;
      done_seen = 0;
      pulse_start();
      tick(45);
      check("burst_done_count", done_seen, 1);

      // Zero beeps
      beep_count = 0;
      done_seen = 0;
      pulse_start();
      tick(4);
      check("zero_done_count", done_seen, 1);

      // Start and mode changes mid-burst are ignored; restart on the done cycle
      beep_count = 2; on_len = 5; off_len = 3; tone_div = 0;
      done_seen = 0;
      pulse_start();
      tick(4);
      beep_count = 7; on_len = 1; tone_div = 5;
      pulse_start();
      mode = 1'b0; en = 1'b1;
      tick(3);
      mode = 1'b1;
      waited = 0;
      while (!done && waited < 100) begin
         tick(1);
         waited++;
      end
      check("wait_done", {31'd0, done}, 32'd1);
      check("ignored_done_count", done_seen, 1);
      beep_count = 1; on_len = 4; tone_div = 1;
      pulse_start();
      check("restart_busy", {31'd0, busy}, 32'd1);
      tick(10);

      // Reset during the second ON window
      beep_count = 3; on_len = 7; off_len = 3; tone_div = 0;
      done_seen = 0;
      pulse_start();
      tick(13);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(30);
      check("reset_abort_done", done_seen, 0);

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         mode       = $urandom_range(0, 1);
         en         = $urandom_range(0, 1);
         tone_div   = $urandom_range(0, 6);
         beep_count = $urandom_range(0, 4);
         on_len     = $urandom_range(0, 10);
         off_len    = $urandom_range(0, 10);
         rst        = ($urandom_range(0, 15) != 0);
         start      = ($urandom_range(0, 2) != 0);
         tick(1);
         rst   = 1'b1;
         start = 1'b0;
         if ($urandom_range(0, 1) == 1) tone_div = $urandom_range(0, 6);
         tick($urandom_range(5, 60));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/buzzer_tone_gen.md
# buzzer_tone_gen

Parametrised buzzer driver: square-wave tone with a runtime-programmable half-period, in either a continuous mode or a burst mode that emits N beeps of programmable on/off length. Sits between board-level control logic (a button decoder or sequencer) and the buzzer/speaker pin. It is the generalised successor of the fixed-period toggling buzzer PWM. With `tone_div` = 500000 in continuous mode, its output matches that fixed toggler.

## Interface
- `CNT_W`, 24, tone counter and `tone_div` width
- `DUR_W`, 24, on/off duration counter width
- `NUM_W`, 8, beep count width

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-low (0 = reset)
- `mode`  in  1  0 = continuous, 1 = burst
- `en`  in  1  continuous-mode level enable
- `start`  in  1  burst-mode start pulse, one cycle
- `tone_div`  in  CNT_W  half-period = `tone_div`+1 clk cycles
- `beep_count`  in  NUM_W  beeps per burst
- `on_len`  in  DUR_W  beep on-time = `on_len`+1 cycles
- `off_len`  in  DUR_W  gap = `off_len`+1 cycles
- `pwm_out`  out  1  tone output, registered
- `busy`  out  1  high while a burst is in progress
- `done`  out  1  one-cycle pulse when a burst completes

## Operation
- States: IDLE, CONT, ON, OFF.
- IDLE: `pwm_out`=0, `busy`=0.
  - `mode`=0 and `en`=1 -> CONT.
  - `mode`=1 and `start`=1 and `beep_count`≠0 -> ON. Latch `tone_div`, `on_len`, `off_len` and `beep_count` into `beeps_left`.
  - `mode`=1, `start`=1, `beep_count`=0 -> stay IDLE and pulse `done` the next cycle.
- CONT: tone runs. `en`=0 or `mode`=1 -> IDLE, and `pwm_out` is forced 0 in the same update. `tone_div` is re-sampled at every toggle, so a frequency change takes effect at the next half-period boundary.
- ON: tone runs on the latched `tone_div`. The duration counter counts 0..`on_len`. At `on_len`:
  - if `beeps_left`=1 -> IDLE with `done` pulse;
  - else decrement `beeps_left` and go to OFF.
- OFF: `pwm_out`=0, tone counter held at 0. The duration counter counts 0..`off_len`, then -> ON.
- Tone core: counter clears and `pwm_out`=0 on every entry to CONT or ON. When counter == divisor, the counter clears and `pwm_out` toggles; otherwise the counter increments. `tone_div`=0 toggles every cycle (clk/2).
- During a burst, `start`, `mode`, `en` and live parameter inputs are ignored. There is no queueing.
- All counters are unsigned. Counters never exceed their compare value, so there is no wrap-around beyond the compare.

## Timing
- Reset (`rst`=0 at a clk edge): state IDLE, all counters 0, `pwm_out`=0, `busy`=0, `done`=0. Reset mid-burst aborts immediately with no `done` pulse.
- Entry latency: request seen at edge k -> state CONT/ON from edge k. `busy`=1 from cycle k+1.
- First toggle: `tone_div`+1 cycles after entry. Period = 2·(`tone_div`+1) cycles.
- Burst length = `beep_count`·(`on_len`+1) + (`beep_count`−1)·(`off_len`+1) cycles of ON/OFF.
- `done` is asserted in the first cycle after the final ON cycle. `busy` falls in that same cycle.
- `start` that coincides with the `done` cycle is accepted (state is IDLE).
- `done` and `busy` are never high together.

## Structure
- Shared package `buzzer_pkg`: state enum (IDLE, CONT, ON, OFF) and default width constants `BUZ_CNT_W`, `BUZ_DUR_W`, `BUZ_NUM_W`.
- Sub-module `buzzer_tone_core`: tone counter plus toggle register.
  - Ports: `clk`, `rst`, `run`, `clr`, `div`, `tone`.
  - Instantiated once. The FSM and duration/beep counters stay in the top level.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `en`=1 -> `pwm_out`, `busy`, `done` all 0. Release -> CONT entered, first toggle after `tone_div`+1 cycles.
- Continuous: `mode`=0, `en`=1, `tone_div`=3 -> `pwm_out` period 8 cycles, 50% duty. Change to `tone_div`=1 mid-run -> period becomes 4 after the next toggle. `en`=0 -> `pwm_out`=0 next cycle.
- Burst: `beep_count`=3, `on_len`=9, `off_len`=4, `tone_div`=1 -> three 10-cycle tone windows separated by 5-cycle low gaps. `done` pulses once, 40 cycles after the start edge.
- Zero beeps: `start` with `beep_count`=0 -> `busy` stays 0, one `done` pulse, `pwm_out` stays 0.
- Ignored start: second `start` and `mode` toggle mid-burst -> burst unaffected, exactly one `done`. `start` on the `done` cycle -> new burst begins.
- Reset mid-burst: `rst`=0 during the second ON -> outputs 0 next edge, no `done`, state IDLE.
